rib_xbar: RTL and testbench
===========================

# rib_xbar

Parametrised, registered successor to the RIB bus interconnect. It connects NM masters to NS slaves through one shared transaction path. Arbitration is selectable between fixed-priority and round-robin. Each transfer runs a req/ack handshake on both sides, with a per-transfer timeout and an error response for unmapped or silent slaves. It sits between the core/debug/DMA masters and the memory-mapped peripherals, and drives the pipeline hold flag.

## Interface
- NM, 4: number of masters (2..8)
- NS, 7: number of slaves (1..16)
- AW, 32: address width
- DW, 32: data width
- RR_EN, 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- TO_CYC, 255: cycles in BUSY before timeout (1..65535)
- HOLD_MASK, 4'b1101: masters whose pending request asserts hold_flag_o
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- m_req_i  in  NM  per-master request; held until matching m_ack_o
- m_we_i  in  NM  per-master write enable
- m_addr_i  in  NM*AW  packed addresses, master i at [i*AW +: AW]
- m_wdata_i  in  NM*DW  packed write data
- m_rdata_o  out  NM*DW  packed read data, valid with m_ack_o
- m_ack_o  out  NM  one-cycle completion pulse
- m_err_o  out  NM  error flag, valid with m_ack_o
- s_req_o  out  NS  one-hot slave request
- s_we_o  out  1  write enable to the selected slave
- s_addr_o  out  AW  address with top 4 bits forced to 0
- s_wdata_o  out  DW  write data
- s_rdata_i  in  NS*DW  packed slave read data
- s_ack_i  in  NS  slave completion, sampled only for the selected slave
- hold_flag_o  out  1  pipeline hold request

## Operation
- Slave index = addr[AW-1:AW-4]. An index >= NS is unmapped.
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - If any m_req_i is set, pick a winner and register grant, addr, we, wdata and slave index.
  - Mapped target: go to BUSY.
  - Unmapped target: go to RESP with err=1 and rdata=0.
- BUSY:
  - s_req_o[sel]=1; s_we_o, s_addr_o and s_wdata_o come from the registered copies.
  - On s_ack_i[sel]: latch s_rdata_i[sel], set err=0, go to RESP.
  - When the timeout counter reaches TO_CYC-1 without ack: err=1, rdata=0, go to RESP.
- RESP:
  - m_ack_o[grant]=1, m_err_o[grant]=err, m_rdata_o[grant]=latched data. No arbitration happens in this state. Next state is IDLE.
- Fixed priority: lowest index wins.
- Round-robin:
  - Search starts at last_grant+1, modulo NM.
  - last_grant updates on entry to RESP.
  - last_grant resets to NM-1, so master 0 wins first.
- A master that drops req while BUSY does not abort the transfer; the ack pulse is still issued.
- Non-granted masters:
  - m_ack_o=0 and m_err_o=0.
  - m_rdata_o holds its last value; it is meaningful only with ack.
- hold_flag_o is combinational: |(m_req_i & HOLD_MASK), OR (state != IDLE and HOLD_MASK[grant]).
- Reset mid-transfer: the transfer is dropped. No ack is issued, then or later.

## Timing
- Reset values:
  - Outputs: all m_* = 0, s_req_o=0, s_we_o=0, s_addr_o=0, s_wdata_o=0, hold_flag_o=0.
  - Internal: state=IDLE, timeout counter=0.
- Latency, measured from the IDLE cycle in which a request is seen (cycle 0):
  - BUSY starts at cycle 1.
  - A zero-wait slave (ack in cycle 1) gives m_ack_o in cycle 2, and IDLE returns in cycle 3.
  - Each slave wait cycle adds 1.
- Minimum issue interval is 3 cycles per transfer.
- Unmapped target: m_ack_o with err in cycle 1.
- Timeout: m_ack_o with err in cycle TO_CYC+1.
- The timeout counter clears on entry to BUSY.
- s_ack_i on a non-selected slave, or outside BUSY, is ignored.
- Requests that arrive in RESP wait for the following IDLE.

## Test plan
- Reset: hold rst=0 while requests are active -> every output is 0. Release rst -> first grant goes to master 0.
- Fixed priority (RR_EN=0): m_req_i=4'b1010 held continuously -> master 1 is served every transfer and master 3 starves.
- Round-robin (RR_EN=1): m_req_i=4'b1111 held -> ack order 0,1,2,3,0.
- Master 2 write, addr 0x2000_0010, data 0xDEADBEEF; slave 2 acks after 3 waits -> s_req_o=7'b0000100, s_addr_o=0x0000_0010, m_ack_o[2] in cycle 5 with err=0.
- Unmapped read at 0xF000_0000 with NS=7 -> m_ack_o in cycle 1 with err=1 and rdata=0. Slave with ack tied low, TO_CYC=8 -> err ack in cycle 9.
- Reset asserted in BUSY -> no ack, state=IDLE, and the next request completes normally.

Source files
------------

// File: rtl/rib_xbar.sv
// Shared-path NM x NS req/ack crossbar: fixed-priority or round-robin arbitration, timeout and unmapped-error responses.
// Latency: grant in IDLE, zero-wait slave acks the master two cycles later; masters hold req until ack, no other backpressure.
module rib_xbar #(
  parameter int             NM        = 4,
  parameter int             NS        = 7,
  parameter int             AW        = 32,
  parameter int             DW        = 32,
  parameter int             RR_EN     = 1,
  parameter int             TO_CYC    = 255,
  parameter logic [NM-1:0]  HOLD_MASK = NM'(4'b1101)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NM-1:0]     m_req_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [NM*AW-1:0]  m_addr_i,
  input  logic [NM*DW-1:0]  m_wdata_i,
  output logic [NM*DW-1:0]  m_rdata_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  output logic [NS-1:0]     s_req_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_addr_o,
  output logic [DW-1:0]     s_wdata_o,
  input  logic [NS*DW-1:0]  s_rdata_i,
  input  logic [NS-1:0]     s_ack_i,
  output logic              hold_flag_o
);
  localparam int GW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_q, last_d;
  logic [AW-5:0]      addr_q, addr_d;
  logic               we_q, we_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [3:0]         sel_q, sel_d;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [NM*DW-1:0]   rdata_q, rdata_d;

  logic [GW-1:0]      win, hi_idx, lo_idx;
  logic               win_vld, hi_vld, lo_vld;
  logic [AW-1:0]      new_addr;
  logic               new_we;
  logic [DW-1:0]      new_wdata;
  logic               ack_sel;
  logic [DW-1:0]      rdata_sel;
  logic               rsp_wr;
  logic [DW-1:0]      rsp_dat;
  logic               hold_gnt;

  // hi: lowest requester above last grant (round-robin only); lo: lowest requester otherwise.
  always_comb begin
    hi_idx = '0;
    hi_vld = 1'b0;
    lo_idx = '0;
    lo_vld = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (m_req_i[i]) begin
        if (RR_EN != 0 && i > int'(last_q)) begin
          if (!hi_vld) begin
            hi_idx = GW'(i);
            hi_vld = 1'b1;
          end
        end else if (!lo_vld) begin
          lo_idx = GW'(i);
          lo_vld = 1'b1;
        end
      end
    end
    win_vld = hi_vld | lo_vld;
    win     = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    new_addr  = '0;
    new_we    = 1'b0;
    new_wdata = '0;
    for (int i = 0; i < NM; i++) begin
      if (win == GW'(i)) begin
        new_addr  = m_addr_i[i*AW +: AW];
        new_we    = m_we_i[i];
        new_wdata = m_wdata_i[i*DW +: DW];
      end
    end
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int s = 0; s < NS; s++) begin
      if (sel_q == 4'(s)) begin
        ack_sel   = s_ack_i[s];
        rdata_sel = s_rdata_i[s*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rsp_wr  = 1'b0;
    rsp_dat = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win;
          addr_d  = new_addr[AW-5:0];
          we_d    = new_we;
          wdata_d = new_wdata;
          sel_d   = new_addr[AW-1 -: 4];
          if ({1'b0, new_addr[AW-1 -: 4]} < 5'(NS)) begin
            state_d = BUSY;
            cnt_d   = '0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rsp_wr  = 1'b1;
            last_d  = win;
          end
        end
      end
      BUSY: begin
        if (ack_sel) begin
          state_d = RESP;
          err_d   = 1'b0;
          rsp_wr  = 1'b1;
          rsp_dat = rdata_sel;
          last_d  = grant_q;
        end else if (cnt_q == 16'(TO_CYC - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rsp_wr  = 1'b1;
          last_d  = grant_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Response data lands in the winner's own slot so other masters keep their last value.
    for (int i = 0; i < NM; i++) begin
      if (rsp_wr && grant_d == GW'(i)) rdata_d[i*DW +: DW] = rsp_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NM - 1);
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    m_ack_o  = '0;
    m_err_o  = '0;
    hold_gnt = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (grant_q == GW'(i)) begin
        m_ack_o[i] = (state_q == RESP);
        m_err_o[i] = (state_q == RESP) && err_q;
        hold_gnt   = HOLD_MASK[i];
      end
    end
    s_req_o = '0;
    for (int s = 0; s < NS; s++) begin
      s_req_o[s] = (state_q == BUSY) && (sel_q == 4'(s));
    end
  end

  assign m_rdata_o   = rdata_q;
  assign s_we_o      = (state_q == BUSY) && we_q;
  assign s_addr_o    = {4'b0000, addr_q};
  assign s_wdata_o   = wdata_q;
  assign hold_flag_o = rst && ((|(m_req_i & HOLD_MASK)) || (state_q != IDLE && hold_gnt));

endmodule

// File: tb/tb_rib_xbar.sv
// Scoreboarded bench for rib_xbar: transaction-level model predicts grant order, ack cycle, err and rdata.
module tb_rib_xbar;
  localparam int NM = 4;
  localparam int NS = 7;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [NM-1:0] HM = 4'b1101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_req_i = '0, m_we_i = '0;
  logic [NM*AW-1:0] m_addr_i = '0;
  logic [NM*DW-1:0] m_wdata_i = '0, m_rdata_o;
  logic [NM-1:0]    m_ack_o, m_err_o;
  logic [NS-1:0]    s_req_o;
  logic [NS-1:0]    s_ack_i = '0;
  logic             s_we_o, hold_flag_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_wdata_o;
  logic [NS*DW-1:0] s_rdata_i = '0;

  rib_xbar #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .RR_EN(1), .TO_CYC(TO), .HOLD_MASK(HM)) dut (
    .clk(clk), .rst(rst), .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_wdata_i(m_wdata_i), .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .hold_flag_o(hold_flag_o));

  // Fixed-priority instance: masters 1 and 3 request forever against an always-ready slave 0.
  logic [NM-1:0]    fp_req = 4'b1010;
  logic [NM-1:0]    fp_we = '0;
  logic [NM*AW-1:0] fp_addr = '0;
  logic [NM*DW-1:0] fp_wdata = '0, fp_rdata;
  logic [NM-1:0]    fp_ack, fp_err;
  logic [NS-1:0]    fp_sreq, fp_sack;
  logic             fp_swe, fp_hold;
  logic [AW-1:0]    fp_saddr;
  logic [DW-1:0]    fp_swdata;
  logic [NS*DW-1:0] fp_srdata = '0;
  assign fp_sack = fp_sreq;

  rib_xbar #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .RR_EN(0), .TO_CYC(255), .HOLD_MASK(HM)) dut_fp (
    .clk(clk), .rst(rst), .m_req_i(fp_req), .m_we_i(fp_we), .m_addr_i(fp_addr),
    .m_wdata_i(fp_wdata), .m_rdata_o(fp_rdata), .m_ack_o(fp_ack), .m_err_o(fp_err),
    .s_req_o(fp_sreq), .s_we_o(fp_swe), .s_addr_o(fp_saddr), .s_wdata_o(fp_swdata),
    .s_rdata_i(fp_srdata), .s_ack_i(fp_sack), .hold_flag_o(fp_hold));

  typedef struct {
    int m; int cyc; logic err; logic [DW-1:0] rd;
  } mexp_t;
  typedef struct {
    int sel; logic [AW-1:0] addr; logic we; logic [DW-1:0] wd; int waits; bit silent; logic [DW-1:0] rd;
  } sexp_t;

  mexp_t mq[$];
  sexp_t sq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr_last = NM - 1;
  logic [DW-1:0] last_rd [NM];
  logic [AW-1:0] t_addr [NM];
  logic          t_we [NM];
  logic [DW-1:0] t_wd [NM];
  logic [DW-1:0] t_rd [NM];
  int            t_wait [NM];
  bit            t_sil [NM];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave side: pops the expected slave transfer, checks it, then acks after the planned waits.
  sexp_t cur;
  int r_cnt = 0;
  bit r_act = 0;
  logic [NS-1:0] s_req_prev = '0;
  always @(negedge clk) begin
    s_ack_i = NS'($urandom);
    for (int s = 0; s < NS; s++) s_rdata_i[s*DW +: DW] = $urandom;
    if (s_req_o != '0) begin
      if (s_req_prev == '0) begin
        if (sq.size() == 0) begin
          chk("slave_unexpected", 64'(s_req_o), 64'd0);
        end else begin
          cur = sq.pop_front();
          r_cnt = cur.waits;
          r_act = 1;
          chk("s_req", 64'(s_req_o), 64'(1) << cur.sel);
          chk("s_addr", 64'(s_addr_o), {32'd0, 4'h0, cur.addr[AW-5:0]});
          chk("s_we", 64'(s_we_o), 64'(cur.we));
          chk("s_wdata", 64'(s_wdata_o), 64'(cur.wd));
        end
      end
      if (r_act) begin
        s_ack_i[cur.sel] = !cur.silent && (r_cnt == 0);
        if (r_cnt > 0) r_cnt--;
        s_rdata_i[cur.sel*DW +: DW] = cur.rd;
      end
    end else begin
      r_act = 0;
    end
    s_req_prev = s_req_o;
  end

  mexp_t me_mon;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NM; i++) last_rd[i] = '0;
    end
    if (m_ack_o != '0) begin
      if (mq.size() == 0) begin
        chk("ack_unexpected", 64'(m_ack_o), 64'd0);
      end else begin
        me_mon = mq.pop_front();
        chk("ack_master", 64'(m_ack_o), 64'(1) << me_mon.m);
        chk("ack_cycle", 64'(cyc), 64'(me_mon.cyc));
        chk("ack_err", 64'(m_err_o), me_mon.err ? (64'(1) << me_mon.m) : 64'd0);
        chk("ack_rdata", 64'(m_rdata_o[me_mon.m*DW +: DW]), 64'(me_mon.rd));
        last_rd[me_mon.m] = me_mon.rd;
        for (int i = 0; i < NM; i++)
          if (i != me_mon.m) chk("rdata_hold", 64'(m_rdata_o[i*DW +: DW]), 64'(last_rd[i]));
      end
    end else if (m_err_o != '0) begin
      chk("err_without_ack", 64'(m_err_o), 64'd0);
    end
  end

  int fp_last = -1;
  always @(negedge clk) begin
    if (!rst) fp_last = -1;
    else if (fp_ack != '0) begin
      chk("fp_winner", 64'(fp_ack), 64'h2);
      if (fp_last >= 0) chk("fp_interval", 64'(cyc - fp_last), 64'd3);
      fp_last = cyc;
    end
  end

  task automatic gen(input int i);
    int idx;
    idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, NS - 1));
    t_addr[i] = {4'(idx), 28'($urandom)};
    t_we[i]   = 1'($urandom);
    t_wd[i]   = $urandom;
    t_rd[i]   = $urandom;
    t_wait[i] = $urandom_range(0, 4);
    t_sil[i]  = ($urandom_range(0, 9) == 0);
  endtask

  // Issues all masters in mask at once from IDLE and predicts the whole service sequence.
  task automatic do_round(input logic [NM-1:0] mask, input bit drop, input int hold_exp);
    logic [NM-1:0] rem, pend;
    int t, m, idx;
    mexp_t me;
    sexp_t se;
    @(negedge clk);
    for (int i = 0; i < NM; i++) begin
      m_req_i[i] = mask[i];
      m_we_i[i]  = t_we[i];
      m_addr_i[i*AW +: AW]  = t_addr[i];
      m_wdata_i[i*DW +: DW] = t_wd[i];
    end
    rst = 1'b1;
    rem = mask;
    t = cyc;
    while (rem != '0) begin
      m = -1;
      for (int k = 1; k <= NM; k++)
        if (m < 0 && rem[(rr_last + k) % NM]) m = (rr_last + k) % NM;
      idx = int'(t_addr[m][AW-1 -: 4]);
      me.m = m;
      if (idx >= NS) begin
        me.err = 1'b1; me.rd = '0; me.cyc = t + 1; t += 2;
      end else begin
        se.sel = idx; se.addr = t_addr[m]; se.we = t_we[m]; se.wd = t_wd[m];
        se.waits = t_wait[m]; se.silent = t_sil[m]; se.rd = t_rd[m];
        sq.push_back(se);
        if (t_sil[m]) begin
          me.err = 1'b1; me.rd = '0; me.cyc = t + TO + 1; t += TO + 2;
        end else begin
          me.err = 1'b0; me.rd = t_rd[m]; me.cyc = t + 2 + t_wait[m]; t += 3 + t_wait[m];
        end
      end
      mq.push_back(me);
      rem[m] = 1'b0;
      rr_last = m;
    end
    #1 chk("hold_idle", 64'(hold_flag_o), 64'(|(mask & HM)));
    pend = mask;
    for (int n = 1; n <= 300 && pend != '0; n++) begin
      @(negedge clk);
      if (n == 1 && drop) m_req_i = '0;
      #1;
      if (n == 1 && hold_exp >= 0) chk("hold_busy", 64'(hold_flag_o), 64'(hold_exp));
      pend    = pend & ~m_ack_o;
      m_req_i = m_req_i & ~m_ack_o;
    end
    if (pend != '0) chk("round_timeout", 64'(pend), 64'd0);
    m_req_i = '0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  sexp_t se_rst;
  initial begin
    rst = 1'b0;
    m_req_i = '1;
    for (int i = 0; i < NM; i++) m_addr_i[i*AW +: AW] = $urandom;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_m_ack", 64'(m_ack_o), 64'd0);
    chk("rst_m_err", 64'(m_err_o), 64'd0);
    chk("rst_m_rdata", 64'(|m_rdata_o), 64'd0);
    chk("rst_s_req", 64'(s_req_o), 64'd0);
    chk("rst_s_we", 64'(s_we_o), 64'd0);
    chk("rst_s_addr", 64'(s_addr_o), 64'd0);
    chk("rst_s_wdata", 64'(s_wdata_o), 64'd0);
    chk("rst_hold", 64'(hold_flag_o), 64'd0);

    for (int i = 0; i < NM; i++) gen(i);
    do_round(4'b1111, 0, -1);
    gen(0);
    do_round(4'b0001, 0, -1);

    t_addr[2] = 32'h2000_0010; t_we[2] = 1'b1; t_wd[2] = 32'hDEAD_BEEF;
    t_rd[2] = $urandom; t_wait[2] = 3; t_sil[2] = 0;
    do_round(4'b0100, 1, 1);

    t_addr[3] = 32'hF000_0000; t_we[3] = 1'b0; t_wd[3] = $urandom;
    do_round(4'b1000, 0, -1);

    t_addr[1] = 32'h5000_0040; t_we[1] = 1'b0; t_sil[1] = 1; t_wait[1] = 0;
    do_round(4'b0010, 0, 0);

    se_rst.sel = 3; se_rst.addr = 32'h3000_0100; se_rst.we = 1'b0; se_rst.wd = 32'h1234_5678;
    se_rst.waits = 5; se_rst.silent = 0; se_rst.rd = $urandom;
    sq.push_back(se_rst);
    @(negedge clk);
    m_req_i = 4'b0010;
    m_we_i[1] = 1'b0;
    m_addr_i[1*AW +: AW] = se_rst.addr;
    m_wdata_i[1*DW +: DW] = se_rst.wd;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_s_req", 64'(s_req_o), 64'd0);
    chk("midrst_m_ack", 64'(m_ack_o), 64'd0);
    chk("midrst_m_rdata", 64'(|m_rdata_o), 64'd0);
    m_req_i = '0;
    rr_last = NM - 1;
    repeat (3) @(negedge clk);
    gen(1); t_addr[1][AW-1 -: 4] = 4'h4; t_sil[1] = 0;
    do_round(4'b0010, 0, 0);

    for (int r = 0; r < 120; r++) begin
      for (int i = 0; i < NM; i++) gen(i);
      do_round(NM'($urandom_range(1, (1 << NM) - 1)), 0, -1);
    end

    repeat (5) @(negedge clk);
    chk("mq_drained", 64'(mq.size()), 64'd0);
    chk("sq_drained", 64'(sq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
